// File: rtl/fixed_point_divider.sv
// fixed_point_divider: sequential signed M.Q fixed-point divider, radix-2 restoring, one quotient bit per cycle
module fixed_point_divider #(
  parameter int M = 15,
  parameter int Q = 16,
  localparam int W = M + Q + 1,
  localparam int N = W + Q
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] quotient,
  output logic         overflow,
  output logic         div_by_zero
);
  localparam logic [1:0] IDLE = 2'd0, DIV = 2'd1, FIX = 2'd2, DONE = 2'd3;
  localparam int CW = $clog2(N + 1);
  localparam logic [W-1:0] MAXP = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] MAXN = {1'b1, {(W-1){1'b0}}};
  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic          sign, a_neg;
  logic [W-1:0]  rem, den, a_mag, b_mag;
  logic [N-1:0]  num, mq;
  logic [W:0]    rem_sh;
  logic          ge, ovf;
  assign a_mag = dividend[W-1] ? -dividend : dividend;
  assign b_mag = divisor[W-1] ? -divisor : divisor;
  assign rem_sh = {rem, num[N-1]};
  assign ge = rem_sh >= {1'b0, den};
  // a negative result may reach one past the positive limit (the most-negative word)
  assign ovf = mq > {{Q{1'b0}}, sign ? MAXN : MAXP};
  assign in_ready = rst_n && state == IDLE;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      sign        <= 1'b0;
      a_neg       <= 1'b0;
      rem         <= '0;
      den         <= '0;
      num         <= '0;
      mq          <= '0;
      out_valid   <= 1'b0;
      quotient    <= '0;
      overflow    <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          sign  <= dividend[W-1] ^ divisor[W-1];
          a_neg <= dividend[W-1];
          rem   <= '0;
          num   <= {a_mag, {Q{1'b0}}};
          den   <= b_mag;
          mq    <= '0;
          cnt   <= CW'(N);
          state <= DIV;
        end
        DIV: begin
          rem   <= ge ? W'(rem_sh - {1'b0, den}) : rem_sh[W-1:0];
          num   <= num << 1;
          mq    <= {mq[N-2:0], ge};
          cnt   <= cnt - 1'b1;
          state <= cnt == CW'(1) ? FIX : DIV;
        end
        FIX: begin
          div_by_zero <= den == '0;
          overflow    <= den != '0 && ovf;
          quotient    <= den == '0 ? (a_neg ? MAXN : MAXP) :
                         ovf ? (sign ? MAXN : MAXP) :
                         sign ? -mq[W-1:0] : mq[W-1:0];
          out_valid   <= 1'b1;
          state       <= DONE;
        end
        default: if (out_ready) begin
          out_valid   <= 1'b0;
          overflow    <= 1'b0;
          div_by_zero <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fixed_point_divider.sv
// tb_fixed_point_divider: scoreboard bench for fixed_point_divider against a longint reference model
module tb_fixed_point_divider;
  localparam int W = 32;
  localparam int N = 48;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [W-1:0] dividend = '0, divisor = '0;
  logic in_ready, out_valid, overflow, div_by_zero;
  logic [W-1:0] quotient;
  int checks = 0, errors = 0;
  logic [W+1:0] sb[$];
  fixed_point_divider dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor), .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .overflow(overflow), .div_by_zero(div_by_zero)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask
  // returns {div_by_zero, overflow, quotient}
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb_, na, nb, mq, r;
    logic neg;
    sa = longint'($signed(a));
    sb_ = longint'($signed(b));
    na = sa < 0 ? -sa : sa;
    nb = sb_ < 0 ? -sb_ : sb_;
    neg = a[W-1] ^ b[W-1];
    if (b == '0) return {2'b10, a[W-1] ? 32'h8000_0000 : 32'h7FFF_FFFF};
    mq = (na <<< 16) / nb;
    if (mq > (neg ? 64'sd2147483648 : 64'sd2147483647)) return {2'b01, neg ? 32'h8000_0000 : 32'h7FFF_FFFF};
    r = neg ? -mq : mq;
    return {2'b00, r[31:0]};
  endfunction
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int hold);
    int c;
    logic [W+1:0] e;
    logic [W-1:0] q0;
    @(negedge clk);
    dividend = a;
    divisor = b;
    in_valid = 1'b1;
    c = 0;
    while (!in_ready && c < 100) begin
      @(negedge clk);
      c++;
    end
    chk("accept_ready", W'(in_ready), 1);
    sb.push_back(model(a, b));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    dividend = $urandom;
    divisor = $urandom;
    @(negedge clk);
    c = 1;
    chk("busy_in_ready", W'(in_ready), 0);
    while (!out_valid && c < 200) begin
      @(negedge clk);
      c++;
    end
    chk("latency", W'(c), W'(N + 2));
    q0 = quotient;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_q", quotient, q0);
      chk("hold_valid", W'(out_valid), 1);
      chk("hold_in_ready", W'(in_ready), 0);
    end
    if (sb.size() == 0) chk("sb_empty", 1, 0);
    else begin
      e = sb.pop_front();
      chk("quotient", quotient, e[W-1:0]);
      chk("overflow", W'(overflow), W'(e[W]));
      chk("div_by_zero", W'(div_by_zero), W'(e[W+1]));
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("post_valid", W'(out_valid), 0);
    chk("post_flags", W'({overflow, div_by_zero}), 0);
    chk("post_in_ready", W'(in_ready), 1);
  endtask
  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", W'(out_valid), 0);
    chk("rst_quotient", quotient, 0);
    chk("rst_flags", W'({overflow, div_by_zero}), 0);
    chk("rst_in_ready", W'(in_ready), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", W'(in_ready), 1);
    run_op(32'h0003_0000, 32'h0002_0000, 0);
    run_op(32'hFFFF_0000, 32'h0003_0000, 0);
    run_op(32'h0001_0000, 32'h0000_0000, 0);
    run_op(32'hFFFF_0000, 32'h0000_0000, 0);
    run_op(32'h4000_0000, 32'h0000_0001, 0);
    run_op(32'h8000_0000, 32'hFFFF_0000, 0);
    run_op(32'h8000_0000, 32'h0001_0000, 0);
    run_op(32'h0000_0000, 32'hFFFF_0000, 0);
    run_op(32'h0000_0000, 32'h0000_0000, 0);
    run_op(32'h7FFF_FFFF, 32'h7FFF_FFFF, 0);
    run_op(32'h0005_8000, 32'hFFFE_0000, 10);
    @(negedge clk);
    dividend = 32'h0007_0000;
    divisor = 32'h0002_0000;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("abort_valid", W'(out_valid), 0);
    chk("abort_in_ready", W'(in_ready), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_idle", W'(in_ready), 1);
    repeat (N + 5) @(negedge clk);
    chk("abort_no_result", W'(out_valid), 0);
    run_op(32'hFFFD_0000, 32'h0004_0000, 0);
    for (int i = 0; i < 6; i++) run_op($urandom, {$urandom_range(0, 1) ? 16'hFFFF : 16'h0000, 16'($urandom)}, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
